uart_wb_dbg_ctrl: RTL and testbench

Command sequencer for the UART debug bridge in the management SoC. It parses the host byte stream from the UART receiver and runs the matching Wishbone master cycles on the debug bus. Read data is returned to the UART transmitter. It sits between the UART PHY byte streams and the Wishbone interconnect's debug master port.

---
 rtl/uart_wb_dbg_pkg.sv | 17 +
 rtl/uart_wb_dbg_ctrl_timer.sv | 33 +++
 rtl/uart_wb_dbg_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_wb_dbg_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_dbg_pkg.sv
// Shared constants and FSM state encoding for the UART-to-Wishbone debug bridge.
package uart_wb_dbg_pkg;

  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_READ  = 8'h02;
  localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZE,
    S_ADDR,
    S_WDATA,
    S_WB,
    S_RTX
  } state_t;

endpackage

// File: rtl/uart_wb_dbg_ctrl_timer.sv
// Saturating cycle counter: clear wins over enable, expire flags LIMIT reached while enabled.
module dbg_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != LIM) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == LIM);

endmodule

// File: rtl/uart_wb_dbg_ctrl.sv
// Parses host command bytes from the UART and runs Wishbone read/write bursts;
// read data is streamed back MSB first.
module uart_wb_dbg_ctrl
  import uart_wb_dbg_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1_000_000,
  parameter int unsigned WB_TIMEOUT   = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shift_q, shift_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        rx_fire, in_rx, byte_expire, wb_expire, wb_term;
  logic [31:0] shifted, rd_word;

  assign rx_ready = (state_q inside {S_IDLE, S_SIZE, S_ADDR, S_WDATA});
  assign in_rx    = (state_q inside {S_SIZE, S_ADDR, S_WDATA});
  assign rx_fire  = rx_valid && rx_ready;
  assign shifted  = {shift_q[23:0], rx_data};
  assign wb_term  = wb_ack_i || wb_err_i || wb_expire;
  // Anything but a clean ack (err, ack+err, or timeout) reads back as the fill value.
  assign rd_word  = (wb_err_i || !wb_ack_i) ? ERR_DATA : wb_dat_i;

  dbg_timer #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (rx_fire || !in_rx),
    .en     (in_rx),
    .expire (byte_expire)
  );

  dbg_timer #(.LIMIT(WB_TIMEOUT)) u_wb_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (!cyc_q),
    .en     (cyc_q),
    .expire (wb_expire)
  );

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          is_rd_d = (rx_data == CMD_READ);
          state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        if (rx_fire) begin
          cnt_d   = rx_data;
          bcnt_d  = 2'd0;
          state_d = S_ADDR;
        end else if (byte_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          shift_d = shifted;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            adr_d = shifted[31:2];
            if (cnt_q == 8'd0) begin
              state_d = S_IDLE;
            end else if (is_rd_q) begin
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = 4'hF;
              state_d = S_WB;
            end else begin
              state_d = S_WDATA;
            end
          end
        end else if (byte_expire) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          shift_d = shifted;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            dat_d   = shifted;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'hF;
            state_d = S_WB;
          end
        end else if (byte_expire) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (wb_term) begin
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = 4'h0;
          adr_d  = adr_q + 30'd1;
          cnt_d  = cnt_q - 8'd1;
          bcnt_d = 2'd0;
          if (is_rd_q) begin
            shift_d    = rd_word;
            tx_data_d  = rd_word[31:24];
            tx_valid_d = 1'b1;
            state_d    = S_RTX;
          end else if (cnt_q == 8'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_RTX: begin
        if (tx_valid_q && tx_ready) begin
          bcnt_d    = bcnt_q + 2'd1;
          shift_d   = {shift_q[23:0], 8'h00};
          tx_data_d = shift_q[23:16];
          if (bcnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            if (cnt_q != 8'd0) begin
              cyc_d   = 1'b1;
              sel_d   = 4'hF;
              state_d = S_WB;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_wb_dbg_ctrl.sv
// Directed bench: commands are pushed to bus/tx scoreboards as they are sent,
// and a per-cycle monitor pops and compares what the bridge actually produces.
module tb_uart_wb_dbg_ctrl;

  localparam int BYTE_TO = 16;
  localparam int WB_TO   = 8;
  localparam int M_MEM   = 0;
  localparam int M_ADR   = 1;
  localparam int M_ERR   = 2;
  localparam int M_NOACK = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [29:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  uart_wb_dbg_ctrl #(.BYTE_TIMEOUT(BYTE_TO), .WB_TIMEOUT(WB_TO)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .busy     (busy)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  wb_exp_t     exp_wb[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_mem[logic [29:0]];
  logic [31:0] slv_mem[logic [29:0]];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   slv_mode = M_MEM;
  int   slv_wait = 0;
  int   cyc_len = 0;
  logic prev_cyc = 1'b0;
  logic hold_valid = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wb_exp_t e;
    if (wb_cyc_o && !prev_cyc) begin
      chk("wb_cycle_expected", 64'(exp_wb.size() != 0), 64'(1));
      if (exp_wb.size() != 0) begin
        e = exp_wb.pop_front();
        chk("wb_we", 64'(wb_we_o), 64'(e.we));
        chk("wb_adr", 64'(wb_adr_o), 64'(e.adr));
        chk("wb_sel", 64'(wb_sel_o), 64'(4'hF));
        chk("wb_stb", 64'(wb_stb_o), 64'(1));
        if (e.we) chk("wb_dat", 64'(wb_dat_o), 64'(e.dat));
      end
      cyc_len = 0;
    end
    if (wb_cyc_o) cyc_len++;
    if (!wb_cyc_o && prev_cyc) chk("wb_len_bounded", 64'(cyc_len <= WB_TO + 1), 64'(1));
    prev_cyc = wb_cyc_o;

    if (tx_valid && tx_ready) begin
      chk("tx_byte_expected", 64'(exp_tx.size() != 0), 64'(1));
      if (exp_tx.size() != 0) chk("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
    if (tx_valid && !tx_ready) begin
      if (hold_valid) chk("tx_hold_stable", 64'(tx_data), 64'(hold_data));
      hold_data  = tx_data;
      hold_valid = 1'b1;
    end else begin
      hold_valid = 1'b0;
    end
  endtask

  task automatic slave();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      slv_wait++;
      if (slv_wait >= 2) begin
        case (slv_mode)
          M_MEM: begin
            wb_ack_i = 1'b1;
            if (wb_we_o) slv_mem[wb_adr_o] = wb_dat_o;
            else wb_dat_i = slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o] : 32'h0;
          end
          M_ADR: begin
            wb_ack_i = 1'b1;
            wb_dat_i = {wb_adr_o, 2'b00};
          end
          M_ERR: begin
            wb_ack_i = 1'b1;
            wb_err_i = 1'b1;
            wb_dat_i = 32'h1234_5678;
          end
          default: ;
        endcase
      end
    end else begin
      slv_wait = 0;
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    monitor();
    @(posedge sys_clk);
    #1;
    slave();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      done = rx_ready;
      step();
    end
    rx_valid = 1'b0;
    chk("rx_accept", 64'(done), 64'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (busy || exp_tx.size() != 0); i++) step();
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic send_addr(input logic [7:0] cmd, input logic [7:0] n, input logic [31:0] addr);
    send_byte(cmd);
    send_byte(n);
    for (int b = 3; b >= 0; b--) send_byte(addr[8*b +: 8]);
  endtask

  task automatic wr_cmd(input logic [31:0] addr, input logic [7:0] n, input logic [31:0] base);
    logic [29:0] a;
    logic [31:0] d;
    for (int i = 0; i < int'(n); i++) begin
      a = addr[31:2] + 30'(i);
      d = base + 32'(i) * 32'h0101_0101;
      exp_wb.push_back('{we: 1'b1, adr: a, dat: d});
      exp_mem[a] = d;
    end
    send_addr(8'h01, n, addr);
    for (int i = 0; i < int'(n); i++) begin
      d = base + 32'(i) * 32'h0101_0101;
      for (int b = 3; b >= 0; b--) send_byte(d[8*b +: 8]);
    end
    wait_idle();
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input logic [7:0] n);
    logic [29:0] a;
    logic [31:0] w;
    for (int i = 0; i < int'(n); i++) begin
      a = addr[31:2] + 30'(i);
      exp_wb.push_back('{we: 1'b0, adr: a, dat: 32'h0});
      case (slv_mode)
        M_MEM:   w = exp_mem.exists(a) ? exp_mem[a] : 32'h0;
        M_ADR:   w = {a, 2'b00};
        default: w = 32'hFFFF_FFFF;
      endcase
      for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    end
    send_addr(8'h02, n, addr);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("rst_stb", 64'(wb_stb_o), 64'(0));
    chk("rst_we", 64'(wb_we_o), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_adr", 64'(wb_adr_o), 64'(0));
    chk("rst_dat", 64'(wb_dat_o), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_sel", 64'(wb_sel_o), 64'(0));
    chk("rst_rx_ready", 64'(rx_ready), 64'(1));
    step();
    step();
    sys_rst = 1'b0;
    step();

    // Single write then read-back
    slv_mode = M_MEM;
    wr_cmd(32'h0040_0024, 8'd1, 32'h7755_55ab);
    rd_cmd(32'h0040_0024, 8'd1);
    wait_idle();

    // Junk byte dropped, then a 2-word write and read-back
    send_byte(8'h55);
    step();
    chk("junk_dropped_idle", 64'(busy), 64'(0));
    wr_cmd(32'h0000_0100, 8'd2, 32'hdead_beef);
    rd_cmd(32'h0000_0100, 8'd2);
    wait_idle();

    // Read burst across a page with a mid-word tx stall
    slv_mode = M_ADR;
    rd_cmd(32'h0000_0FFC, 8'd3);
    for (int i = 0; i < 500 && exp_tx.size() > 10; i++) step();
    tx_ready = 1'b0;
    chk("tx_valid_at_stall", 64'(tx_valid), 64'(1));
    repeat (5) step();
    tx_ready = 1'b1;
    wait_idle();

    // Zero-length write and read: no bus cycles, no reply
    slv_mode = M_MEM;
    wr_cmd(32'h0000_0200, 8'd0, 32'h0);
    rd_cmd(32'h0000_0200, 8'd0);
    wait_idle();

    // Byte timeout after two address bytes, then a clean read
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h40);
    repeat (20) step();
    chk("byte_timeout_idle", 64'(busy), 64'(0));
    rd_cmd(32'h0040_0024, 8'd1);
    wait_idle();

    // Error (ack+err together) and missing ack both read back as all ones
    slv_mode = M_ERR;
    rd_cmd(32'h0000_0010, 8'd1);
    wait_idle();
    slv_mode = M_NOACK;
    rd_cmd(32'h0000_0020, 8'd1);
    wait_idle();

    // Reset while strobe is high
    rd_cmd(32'h0000_0040, 8'd1);
    for (int i = 0; i < 50 && !wb_cyc_o; i++) step();
    chk("cyc_before_reset", 64'(wb_cyc_o), 64'(1));
    sys_rst = 1'b1;
    #1;
    chk("async_rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("async_rst_stb", 64'(wb_stb_o), 64'(0));
    exp_wb.delete();
    exp_tx.delete();
    step();
    step();
    sys_rst = 1'b0;
    chk("post_rst_rx_ready", 64'(rx_ready), 64'(1));
    step();
    chk("post_rst_busy", 64'(busy), 64'(0));
    slv_mode = M_MEM;
    rd_cmd(32'h0040_0024, 8'd1);
    wait_idle();

    repeat (3) step();
    chk("wb_scoreboard_drained", 64'(exp_wb.size()), 64'(0));
    chk("tx_scoreboard_drained", 64'(exp_tx.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
